// File: rtl/spart_word_bridge.sv
// UART-to-word bridge: RX bytes assembled into little-endian words,
// TX bursts of words fetched from SDRAM and serialised LSB byte first.
module spart_word_bridge #(
  parameter int unsigned CLK_DIV         = 5208,
  parameter int unsigned BYTES           = 2,
  parameter int unsigned CNT_W           = 23,
  parameter int unsigned RX_TIMEOUT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  output logic [8*BYTES-1:0]   rx_word,
  output logic                 rx_word_val,
  output logic [CNT_W-1:0]     rx_word_cnt,
  output logic [7:0]           frame_err_cnt,
  input  logic                 start_tx,
  input  logic [CNT_W-1:0]     burst_len,
  output logic                 rd_req,
  input  logic [8*BYTES-1:0]   rd_word,
  input  logic                 rd_val,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [CNT_W-1:0]     tx_word_cnt
);

  localparam int unsigned W      = 8 * BYTES;
  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned TO_CYC = RX_TIMEOUT_BITS * CLK_DIV;
  localparam int unsigned TO_W   = $clog2(TO_CYC + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT, TX_SEND} tx_state_t;

  // ---------------------------------------------------------------- RX
  logic             rxd_meta, rxd_s, rxd_d;
  rx_state_t        rx_state, rx_state_nxt;
  logic             rx_samp_c;
  logic             rx_fall_c;
  logic [DIV_W-1:0] rx_tick;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic [IDX_W-1:0] rx_idx;
  logic [W-1:0]     rx_buf;
  logic [W-1:0]     rx_asm_c;
  logic [TO_W-1:0]  rx_to;

  // Two-flop synchroniser plus one delay flop for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_d    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_d    <= rxd_s;
    end
  end

  assign rx_fall_c = rxd_d & ~rxd_s;

  // RX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_state_nxt;
  end

  // RX next state and bit-sample strobe
  always_comb begin
    rx_state_nxt = rx_state;
    rx_samp_c    = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall_c) rx_state_nxt = RX_START;
      RX_START: if (rx_tick == HALF_LAST) begin
                  rx_samp_c    = 1'b1;
                  rx_state_nxt = rxd_s ? RX_IDLE : RX_DATA;
                end
      RX_DATA:  if (rx_tick == DIV_LAST) begin
                  rx_samp_c = 1'b1;
                  if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                end
      RX_STOP:  if (rx_tick == DIV_LAST) begin
                  rx_samp_c    = 1'b1;
                  rx_state_nxt = RX_IDLE;
                end
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  // Partial word with the just-received byte inserted at the current index
  always_comb begin
    rx_asm_c = rx_buf;
    for (int unsigned k = 0; k < BYTES; k++) begin
      if (rx_idx == IDX_W'(k)) rx_asm_c[8*k +: 8] = rx_shift;
    end
  end

  // RX datapath: bit timing, shift, word assembly, counters, idle timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_tick       <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_idx        <= '0;
      rx_buf        <= '0;
      rx_to         <= '0;
      rx_word       <= '0;
      rx_word_val   <= 1'b0;
      rx_word_cnt   <= '0;
      frame_err_cnt <= '0;
    end else begin
      rx_word_val <= 1'b0;

      if (rx_state == RX_IDLE || rx_samp_c) rx_tick <= '0;
      else                                  rx_tick <= rx_tick + DIV_W'(1);

      if (rx_state == RX_START) begin
        rx_bit <= '0;
      end else if (rx_state == RX_DATA && rx_samp_c) begin
        rx_shift <= {rxd_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end

      if (rx_state == RX_STOP && rx_samp_c) begin
        if (!rxd_s) begin
          if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
        end else if (rx_idx == BYTE_LAST) begin
          rx_word     <= rx_asm_c;
          rx_word_val <= 1'b1;
          rx_word_cnt <= rx_word_cnt + CNT_W'(1);
          rx_idx      <= '0;
        end else begin
          rx_buf <= rx_asm_c;
          rx_idx <= rx_idx + IDX_W'(1);
        end
      end

      // Drop a stale partial word after a long idle gap
      if (rx_state != RX_IDLE || rx_idx == '0) begin
        rx_to <= '0;
      end else if (rx_to == TO_LAST) begin
        rx_to  <= '0;
        rx_idx <= '0;
      end else begin
        rx_to <= rx_to + TO_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------- TX
  tx_state_t        tx_state, tx_state_nxt;
  logic             tx_done_nxt;
  logic             tx_bit_end_c, tx_word_end_c, tx_last_c;
  logic [DIV_W-1:0] tx_tick;
  logic [3:0]       tx_bit;
  logic [IDX_W-1:0] tx_byte;
  logic [W-1:0]     tx_data;
  logic [7:0]       tx_cur_byte_c;
  logic [CNT_W-1:0] tx_len;

  // TX state register and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      rd_req   <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      rd_req   <= (tx_state_nxt == TX_REQ);
      tx_busy  <= (tx_state_nxt != TX_IDLE);
      tx_done  <= tx_done_nxt;
    end
  end

  // TX next state and end-of-burst detection
  always_comb begin
    tx_state_nxt  = tx_state;
    tx_done_nxt   = 1'b0;
    tx_bit_end_c  = (tx_tick == DIV_LAST);
    tx_word_end_c = (tx_state == TX_SEND) && tx_bit_end_c &&
                    (tx_bit == 4'd9) && (tx_byte == BYTE_LAST);
    tx_last_c     = ((tx_word_cnt + CNT_W'(1)) == tx_len);
    case (tx_state)
      TX_IDLE: if (start_tx) begin
                 if (burst_len != '0) tx_state_nxt = TX_REQ;
                 else                 tx_done_nxt  = 1'b1;
               end
      TX_REQ:  tx_state_nxt = TX_WAIT;
      TX_WAIT: if (rd_val) tx_state_nxt = TX_SEND;
      TX_SEND: if (tx_word_end_c) begin
                 if (tx_last_c) begin
                   tx_state_nxt = TX_IDLE;
                   tx_done_nxt  = 1'b1;
                 end else begin
                   tx_state_nxt = TX_REQ;
                 end
               end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // Byte of the latched word currently on the wire
  always_comb begin
    tx_cur_byte_c = tx_data[7:0];
    for (int unsigned k = 0; k < BYTES; k++) begin
      if (tx_byte == IDX_W'(k)) tx_cur_byte_c = tx_data[8*k +: 8];
    end
  end

  // TX datapath: burst bookkeeping and bit serialiser (bit 0 start, 1..8 data, 9 stop)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txd         <= 1'b1;
      tx_tick     <= '0;
      tx_bit      <= '0;
      tx_byte     <= '0;
      tx_data     <= '0;
      tx_len      <= '0;
      tx_word_cnt <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (start_tx && burst_len != '0) begin
                   tx_len      <= burst_len;
                   tx_word_cnt <= '0;
                 end
        TX_WAIT: if (rd_val) begin
                   tx_data <= rd_word;
                   tx_tick <= '0;
                   tx_bit  <= '0;
                   tx_byte <= '0;
                   txd     <= 1'b0;
                 end
        TX_SEND: begin
          if (!tx_bit_end_c) begin
            tx_tick <= tx_tick + DIV_W'(1);
          end else begin
            tx_tick <= '0;
            if (tx_bit == 4'd9) begin
              tx_bit <= '0;
              if (tx_byte == BYTE_LAST) begin
                tx_word_cnt <= tx_word_cnt + CNT_W'(1);
                txd         <= 1'b1;
              end else begin
                tx_byte <= tx_byte + IDX_W'(1);
                txd     <= 1'b0;
              end
            end else begin
              tx_bit <= tx_bit + 4'd1;
              txd    <= (tx_bit == 4'd8) ? 1'b1 : tx_cur_byte_c[tx_bit[2:0]];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_word_bridge.sv
// Directed bench for spart_word_bridge: RX assembly, framing errors,
// TX bursts, command edge cases, full duplex with RX timeout, reset.
`timescale 1ns/1ps
module tb_spart_word_bridge;

  localparam int unsigned CLK_DIV         = 8;
  localparam int unsigned BYTES           = 2;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned RX_TIMEOUT_BITS = 4;
  localparam int unsigned W               = 8 * BYTES;
  localparam int          WORD_CYC        = 10 * BYTES * CLK_DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             rxd = 1'b1;
  logic             start_tx = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic [W-1:0]     rd_word = '0;
  logic             rd_val = 1'b0;
  logic             txd;
  logic [W-1:0]     rx_word;
  logic             rx_word_val;
  logic [CNT_W-1:0] rx_word_cnt;
  logic [7:0]       frame_err_cnt;
  logic             rd_req;
  logic             tx_busy;
  logic             tx_done;
  logic [CNT_W-1:0] tx_word_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_req = 0, n_done = 0, n_val = 0;
  int tx_frm_err = 0;
  logic [7:0] tx_q [$];
  logic [W-1:0] mem_data [0:3];

  spart_word_bridge #(
    .CLK_DIV(CLK_DIV), .BYTES(BYTES), .CNT_W(CNT_W), .RX_TIMEOUT_BITS(RX_TIMEOUT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd),
    .rx_word(rx_word), .rx_word_val(rx_word_val), .rx_word_cnt(rx_word_cnt),
    .frame_err_cnt(frame_err_cnt), .start_tx(start_tx), .burst_len(burst_len),
    .rd_req(rd_req), .rd_word(rd_word), .rd_val(rd_val), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_word_cnt(tx_word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // High-cycle counters for the one-cycle strobes
  always @(negedge clk) begin
    if (rd_req === 1'b1)      n_req++;
    if (tx_done === 1'b1)     n_done++;
    if (rx_word_val === 1'b1) n_val++;
  end

  // Serial decoder on txd: sample mid-bit, queue each received byte
  initial begin : tx_mon
    logic [7:0] b;
    b = '0;
    forever begin
      @(posedge clk); #1;
      if (rst === 1'b1 && txd === 1'b0) begin
        repeat (CLK_DIV / 2) @(posedge clk);
        #1;
        if (txd !== 1'b0) tx_frm_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(posedge clk);
          #1;
          b[i] = txd;
        end
        repeat (CLK_DIV) @(posedge clk);
        #1;
        if (txd !== 1'b1) tx_frm_err++;
        tx_q.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CLK_DIV);
    end
    rxd = stop;
    tick(CLK_DIV);
    rxd = 1'b1;
    tick(CLK_DIV);
  endtask

  // Memory responder: 5-cycle read latency, checks word spacing on the wire
  task automatic mem_serve(input int n);
    int k;
    int t_v;
    t_v = 0;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (rd_req !== 1'b1 && k < 3000) begin tick(1); k++; end
      checks++;
      if (k >= 3000) begin
        errors++;
        $display("FAIL mem_rd_req_timeout: word %0d got no rd_req within 3000 cycles", i);
        return;
      end
      if (i > 0) begin
        checks++;
        if ((cyc - t_v) !== WORD_CYC) begin
          errors++;
          $display("FAIL word_time: word %0d took %0d cycles, expected %0d", i - 1, cyc - t_v, WORD_CYC);
        end
      end
      tick(5);
      rd_word = mem_data[i];
      rd_val  = 1'b1;
      tick(1);
      t_v    = cyc;
      rd_val = 1'b0;
    end
    k = 0;
    while (tx_done !== 1'b1 && k < 3000) begin tick(1); k++; end
    checks++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL tx_done_timeout: no tx_done within 3000 cycles");
    end else begin
      checks++;
      if ((cyc - t_v) !== WORD_CYC) begin
        errors++;
        $display("FAIL last_word_time: %0d cycles, expected %0d", cyc - t_v, WORD_CYC);
      end
    end
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if ({txd, rx_word_val, rd_req, tx_busy, tx_done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: {txd,val,req,busy,done}=%b expected 10000",
               {txd, rx_word_val, rd_req, tx_busy, tx_done});
    end
    checks++;
    if (rx_word !== 16'h0000 || rx_word_cnt !== 8'd0 || frame_err_cnt !== 8'd0 || tx_word_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs: rx_word=%h rx_cnt=%0d ferr=%0d tx_cnt=%0d expected all 0",
               rx_word, rx_word_cnt, frame_err_cnt, tx_word_cnt);
    end
    rst = 1'b1;
    tick(20);
    checks++;
    if (n_req !== 0) begin
      errors++;
      $display("FAIL reset_no_req: %0d rd_req cycles after release, expected 0", n_req);
    end
  endtask

  task automatic test_rx_word;
    int v0;
    v0 = n_val;
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    tick(4);
    checks++;
    if (rx_word !== 16'h1234) begin
      errors++;
      $display("FAIL rx_word: got %h expected 1234", rx_word);
    end
    checks++;
    if ((n_val - v0) !== 1) begin
      errors++;
      $display("FAIL rx_val_pulse: %0d high cycles, expected 1", n_val - v0);
    end
    checks++;
    if (rx_word_cnt !== 8'd1) begin
      errors++;
      $display("FAIL rx_cnt: got %0d expected 1", rx_word_cnt);
    end
  endtask

  task automatic test_frame_err;
    int v0;
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    tick(4);
    checks++;
    if (frame_err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL frame_err_cnt: got %0d expected 1", frame_err_cnt);
    end
    checks++;
    if (rx_word !== 16'hBBAA) begin
      errors++;
      $display("FAIL frame_err_word: got %h expected BBAA", rx_word);
    end
    checks++;
    if (rx_word_cnt !== 8'd2) begin
      errors++;
      $display("FAIL frame_err_rx_cnt: got %0d expected 2", rx_word_cnt);
    end
    v0 = n_val;
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(30);
    checks++;
    if (frame_err_cnt !== 8'd1 || rx_word_cnt !== 8'd2 || n_val !== v0) begin
      errors++;
      $display("FAIL glitch: ferr=%0d rx_cnt=%0d val_delta=%0d expected 1,2,0",
               frame_err_cnt, rx_word_cnt, n_val - v0);
    end
  endtask

  task automatic test_tx_burst;
    int r0, d0;
    logic [7:0] exp_b [6];
    exp_b = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    mem_data[0] = 16'h1234;
    mem_data[1] = 16'h5678;
    mem_data[2] = 16'h9ABC;
    tx_q.delete();
    tx_frm_err = 0;
    r0 = n_req;
    d0 = n_done;
    burst_len = 8'd3;
    start_tx  = 1'b1;
    tick(1);
    start_tx = 1'b0;
    checks++;
    if (rd_req !== 1'b1 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL burst_start: rd_req=%b tx_busy=%b expected 1,1", rd_req, tx_busy);
    end
    mem_serve(3);
    tick(2);
    checks++;
    if (tx_q.size() !== 6) begin
      errors++;
      $display("FAIL burst_byte_count: got %0d bytes expected 6", tx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (tx_q[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL burst_byte%0d: got %h expected %h", i, tx_q[i], exp_b[i]);
        end
      end
    end
    checks++;
    if ((n_req - r0) !== 3 || (n_done - d0) !== 1) begin
      errors++;
      $display("FAIL burst_pulses: rd_req cycles=%0d tx_done cycles=%0d expected 3,1", n_req - r0, n_done - d0);
    end
    checks++;
    if (tx_word_cnt !== 8'd3 || tx_busy !== 1'b0 || tx_frm_err !== 0) begin
      errors++;
      $display("FAIL burst_end: tx_cnt=%0d busy=%b frame_errs=%0d expected 3,0,0",
               tx_word_cnt, tx_busy, tx_frm_err);
    end
  endtask

  task automatic test_edge_cmds;
    int r0, d0;
    r0 = n_req;
    burst_len = 8'd0;
    start_tx  = 1'b1;
    tick(1);
    start_tx = 1'b0;
    checks++;
    if (tx_done !== 1'b1 || tx_busy !== 1'b0 || rd_req !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: done=%b busy=%b req=%b expected 1,0,0", tx_done, tx_busy, rd_req);
    end
    tick(20);
    checks++;
    if (n_req !== r0 || tx_word_cnt !== 8'd3 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after: req_delta=%0d tx_cnt=%0d done=%b expected 0,3,0",
               n_req - r0, tx_word_cnt, tx_done);
    end

    mem_data[0] = 16'hC3A5;
    tx_q.delete();
    tx_frm_err = 0;
    r0 = n_req;
    d0 = n_done;
    burst_len = 8'd1;
    start_tx  = 1'b1;
    tick(1);
    start_tx = 1'b0;
    fork
      mem_serve(1);
      begin
        tick(40);
        start_tx  = 1'b1;
        burst_len = 8'd5;
        rd_word   = 16'hFFFF;
        rd_val    = 1'b1;
        tick(1);
        start_tx = 1'b0;
        rd_val   = 1'b0;
      end
    join
    tick(30);
    checks++;
    if (tx_word_cnt !== 8'd1 || (n_req - r0) !== 1 || (n_done - d0) !== 1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_cmds: tx_cnt=%0d req=%0d done=%0d busy=%b expected 1,1,1,0",
               tx_word_cnt, n_req - r0, n_done - d0, tx_busy);
    end
    checks++;
    if (tx_q.size() !== 2 || tx_frm_err !== 0) begin
      errors++;
      $display("FAIL ignore_bytes_count: got %0d bytes, %0d frame errs expected 2,0", tx_q.size(), tx_frm_err);
    end else begin
      checks++;
      if (tx_q[0] !== 8'hA5 || tx_q[1] !== 8'hC3) begin
        errors++;
        $display("FAIL ignore_bytes: got %h %h expected a5 c3", tx_q[0], tx_q[1]);
      end
    end
  endtask

  task automatic test_duplex_timeout;
    int v0;
    mem_data[0] = 16'h4321;
    mem_data[1] = 16'h8765;
    tx_q.delete();
    tx_frm_err = 0;
    v0 = n_val;
    burst_len = 8'd2;
    start_tx  = 1'b1;
    tick(1);
    start_tx = 1'b0;
    fork
      mem_serve(2);
      begin
        send_byte(8'h99, 1'b1);
        tick(40);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
      end
    join
    tick(4);
    checks++;
    if (rx_word !== 16'h0201 || rx_word_cnt !== 8'd3 || (n_val - v0) !== 1) begin
      errors++;
      $display("FAIL rx_timeout: word=%h cnt=%0d val_delta=%0d expected 0201,3,1",
               rx_word, rx_word_cnt, n_val - v0);
    end
    checks++;
    if (tx_q.size() !== 4 || tx_word_cnt !== 8'd2 || tx_frm_err !== 0) begin
      errors++;
      $display("FAIL duplex_tx_count: bytes=%0d tx_cnt=%0d frame_errs=%0d expected 4,2,0",
               tx_q.size(), tx_word_cnt, tx_frm_err);
    end else begin
      checks++;
      if ({tx_q[0], tx_q[1], tx_q[2], tx_q[3]} !== 32'h21436587) begin
        errors++;
        $display("FAIL duplex_tx_bytes: got %h %h %h %h expected 21 43 65 87",
                 tx_q[0], tx_q[1], tx_q[2], tx_q[3]);
      end
    end
  endtask

  task automatic test_reset_mid_send;
    int r0;
    mem_data[0] = 16'h00FF;
    burst_len = 8'd2;
    start_tx  = 1'b1;
    tick(1);
    start_tx = 1'b0;
    tick(5);
    rd_word = 16'h00FF;
    rd_val  = 1'b1;
    tick(1);
    rd_val = 1'b0;
    checks++;
    if (txd !== 1'b0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_send: txd=%b busy=%b expected 0,1", txd, tx_busy);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_tx: txd=%b busy=%b expected 1,0", txd, tx_busy);
    end
    checks++;
    if (rx_word_cnt !== 8'd0 || frame_err_cnt !== 8'd0 || tx_word_cnt !== 8'd0 || rx_word !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset_regs: rx_cnt=%0d ferr=%0d tx_cnt=%0d rx_word=%h expected 0,0,0,0000",
               rx_word_cnt, frame_err_cnt, tx_word_cnt, rx_word);
    end
    tick(2);
    rst = 1'b1;
    r0 = n_req;
    tick(50);
    checks++;
    if (n_req !== r0 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: req_delta=%0d busy=%b expected 0,0", n_req - r0, tx_busy);
    end
  endtask

  initial begin
    test_reset();
    test_rx_word();
    test_frame_err();
    test_tx_burst();
    test_edge_cmds();
    test_duplex_timeout();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
